// File: rtl/mem_data_requester.sv
// Data-port requester: one load/store at a time between MEM stage and memory.
// Optional MEM_REQ_PERF_COUNT_EN adds 16-bit load/store/fault response counters.
module mem_data_requester #(
    parameter int WIDTH   = 32,
    parameter int RAMSIZE = 16,
    parameter int NBANKS  = 6,
    parameter int READLAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_rdata,
    output logic             resp_fault,
    output logic             stall,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
`ifdef MEM_REQ_PERF_COUNT_EN
    ,
    output logic [15:0]      perf_loads,
    output logic [15:0]      perf_stores,
    output logic [15:0]      perf_faults
`endif
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(RAMSIZE * NBANKS);
    localparam logic [3:0]       LAST  = 4'(READLAT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_FAULT = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0] state;
    logic [3:0] cnt;
    logic       accept;
    logic       oor;

    assign req_ready = (state == S_IDLE) & ~rst;
    assign stall     = req_valid & ~req_ready;
    assign accept    = req_valid & req_ready;
    assign oor       = req_addr >= LIMIT;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_fault <= 1'b0;
            mem_we     <= 1'b0;
            mem_a      <= '0;
            mem_wd     <= '0;
        end else begin
            resp_valid <= 1'b0;
            mem_we     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mem_a  <= req_addr;
                        mem_wd <= req_wdata;
                        cnt    <= '0;
                        if (oor) begin
                            state <= S_FAULT;
                        end else if (req_we) begin
                            state  <= S_WRITE;
                            mem_we <= 1'b1;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_WRITE: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b0;
                end
                S_READ: begin
                    if (cnt == LAST) begin
                        state      <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b0;
                        resp_rdata <= mem_rd;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                S_FAULT: begin
                    state      <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_fault <= 1'b1;
                    resp_rdata <= '0;
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef MEM_REQ_PERF_COUNT_EN
    // Request type is kept so the RESP cycle knows which counter to bump.
    logic we_q;
    logic fault_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            we_q        <= 1'b0;
            fault_q     <= 1'b0;
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_faults <= '0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                fault_q <= oor;
            end
            if (state == S_RESP) begin
                if (fault_q)   perf_faults <= perf_faults + 16'd1;
                else if (we_q) perf_stores <= perf_stores + 16'd1;
                else           perf_loads  <= perf_loads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_data_requester.sv
// Directed bench for mem_data_requester: READLAT=1 instance (a) and
// READLAT=3 instance (b) share clock, reset and request fields.
module tb_mem_data_requester;

    logic        clk = 1'b0;
    logic        rst;
    logic        va, vb;
    logic        req_we;
    logic [31:0] req_addr, req_wdata;

    logic        ready_a, rv_a, rf_a, stall_a, we_a;
    logic [31:0] rd_a, ma_a, wd_a, mrd_a;
    logic        ready_b, rv_b, rf_b, stall_b, we_b;
    logic [31:0] rd_b, ma_b, wd_b, mrd_b;
`ifdef MEM_REQ_PERF_COUNT_EN
    logic [15:0] pl_a, ps_a, pf_a, pl_b, ps_b, pf_b;
`endif

    int checks = 0;
    int fails  = 0;
    int we_total_a = 0;

    always #5 clk = ~clk;

    mem_data_requester #(.WIDTH(32), .RAMSIZE(16), .NBANKS(6), .READLAT(1)) u_a (
        .clk(clk), .rst(rst), .req_valid(va), .req_ready(ready_a),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_a), .resp_rdata(rd_a), .resp_fault(rf_a),
        .stall(stall_a), .mem_we(we_a), .mem_a(ma_a), .mem_wd(wd_a),
        .mem_rd(mrd_a)
`ifdef MEM_REQ_PERF_COUNT_EN
        , .perf_loads(pl_a), .perf_stores(ps_a), .perf_faults(pf_a)
`endif
    );

    mem_data_requester #(.WIDTH(32), .RAMSIZE(16), .NBANKS(6), .READLAT(3)) u_b (
        .clk(clk), .rst(rst), .req_valid(vb), .req_ready(ready_b),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv_b), .resp_rdata(rd_b), .resp_fault(rf_b),
        .stall(stall_b), .mem_we(we_b), .mem_a(ma_b), .mem_wd(wd_b),
        .mem_rd(mrd_b)
`ifdef MEM_REQ_PERF_COUNT_EN
        , .perf_loads(pl_b), .perf_stores(ps_b), .perf_faults(pf_b)
`endif
    );

    // Memory models: unwritten words read as 32'hA0000000 | address.
    logic [31:0] arr_a [128];
    logic        wr_a  [128];
    logic [31:0] arr_b [128];
    logic        wr_b  [128];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) begin
                wr_a[i] <= 1'b0;
                wr_b[i] <= 1'b0;
            end
        end else begin
            if (we_a) begin
                arr_a[ma_a[6:0]] <= wd_a;
                wr_a[ma_a[6:0]]  <= 1'b1;
            end
            if (we_b) begin
                arr_b[ma_b[6:0]] <= wd_b;
                wr_b[ma_b[6:0]]  <= 1'b1;
            end
        end
    end

    assign mrd_a = wr_a[ma_a[6:0]] ? arr_a[ma_a[6:0]] : (32'hA000_0000 | ma_a);
    assign mrd_b = wr_b[ma_b[6:0]] ? arr_b[ma_b[6:0]] : (32'hA000_0000 | ma_b);

    always @(negedge clk) if (we_a) we_total_a++;

    // Issue one request on instance a; lat = accept edge to resp_valid seen.
    task automatic op_a(input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_we = we; req_addr = addr; req_wdata = wd; va = 1'b1;
        @(posedge clk);
        #1 va = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv_a && lat < 20);
    endtask

    task automatic test_reset;
        int bad;
        bad = 0;
        rst = 1'b1; va = 1'b1; vb = 1'b1;
        req_we = 1'b1; req_addr = 32'd3; req_wdata = 32'h1234_5678;
        repeat (3) begin
            @(negedge clk);
            if (ready_a !== 1'b0 || ready_b !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL reset_ready: %0d cycles with req_ready high, required 0", bad);
        end
        checks++;
        if (stall_a !== 1'b1) begin
            fails++;
            $display("FAIL reset_stall: stall=%b required 1", stall_a);
        end
        checks++;
        if ({rv_a, rd_a, rf_a, we_a, ma_a, wd_a} !== '0 ||
            {rv_b, rd_b, rf_b, we_b, ma_b, wd_b} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: rv=%b rd=%h rf=%b we=%b a=%h wd=%h required all 0",
                     rv_a, rd_a, rf_a, we_a, ma_a, wd_a);
        end
        rst = 1'b0; va = 1'b0; vb = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_a !== 1'b1 || ready_b !== 1'b1 || ma_a !== 32'd0) begin
            fails++;
            $display("FAIL reset_release: ready=%b/%b mem_a=%h required 1/1 0",
                     ready_a, ready_b, ma_a);
        end
    endtask

    task automatic test_store_load;
        int lat, w0;
        w0 = we_total_a;
        op_a(1'b1, 32'd5, 32'hDEAD_BEEF, lat);
        checks++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL store_latency: %0d required 2", lat);
        end
        checks++;
        if (we_total_a - w0 !== 1 || ma_a !== 32'd5 || wd_a !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL store_port: we_cycles=%0d a=%h wd=%h required 1 5 deadbeef",
                     we_total_a - w0, ma_a, wd_a);
        end
        op_a(1'b0, 32'd5, 32'h0, lat);
        checks++;
        if (lat !== 2) begin
            fails++;
            $display("FAIL load_latency: %0d required 2", lat);
        end
        checks++;
        if (rd_a !== 32'hDEAD_BEEF || rf_a !== 1'b0) begin
            fails++;
            $display("FAIL load_data: rdata=%h fault=%b required deadbeef 0", rd_a, rf_a);
        end
        @(negedge clk);
        checks++;
        if (rv_a !== 1'b0 || rd_a !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL resp_one_cycle: rv=%b rdata=%h required 0 deadbeef", rv_a, rd_a);
        end
    endtask

    task automatic test_range;
        int lat, w0;
        op_a(1'b0, 32'd95, 32'h0, lat);
        checks++;
        if (rf_a !== 1'b0 || rd_a !== 32'hA000_005F || lat !== 2) begin
            fails++;
            $display("FAIL addr95: fault=%b rdata=%h lat=%0d required 0 a000005f 2",
                     rf_a, rd_a, lat);
        end
        w0 = we_total_a;
        op_a(1'b1, 32'd96, 32'h5555_AAAA, lat);
        checks++;
        if (rf_a !== 1'b1 || we_total_a - w0 !== 0 || lat !== 2) begin
            fails++;
            $display("FAIL addr96: fault=%b we_cycles=%0d lat=%0d required 1 0 2",
                     rf_a, we_total_a - w0, lat);
        end
        op_a(1'b0, 32'hFFFF_FFFF, 32'h0, lat);
        checks++;
        if (rf_a !== 1'b1 || rd_a !== 32'h0) begin
            fails++;
            $display("FAIL addr_max: fault=%b rdata=%h required 1 0", rf_a, rd_a);
        end
    endtask

    task automatic test_stall;
        int lat, busy, bad;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'd7; req_wdata = 32'h0; vb = 1'b1;
        @(posedge clk);
        lat = 0; busy = 0; bad = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!ready_b) begin
                busy++;
                if (stall_b !== 1'b1) bad++;
            end
        end while (!rv_b && lat < 20);
        checks++;
        if (lat !== 4 || rd_b !== 32'hA000_0007) begin
            fails++;
            $display("FAIL stall_load: lat=%0d rdata=%h required 4 a0000007", lat, rd_b);
        end
        checks++;
        if (busy !== 4 || bad !== 0) begin
            fails++;
            $display("FAIL stall_flag: busy=%0d no_stall=%0d required 4 0", busy, bad);
        end
        @(negedge clk);
        checks++;
        if (ready_b !== 1'b1 || stall_b !== 1'b0) begin
            fails++;
            $display("FAIL after_resp_idle: ready=%b stall=%b required 1 0", ready_b, stall_b);
        end
        @(posedge clk);
        #1;
        vb = 1'b0;
        checks++;
        if (ready_b !== 1'b0) begin
            fails++;
            $display("FAIL next_accept: ready=%b required 0", ready_b);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rv_b && lat < 20);
        checks++;
        if (lat !== 4) begin
            fails++;
            $display("FAIL second_load_latency: %0d required 4", lat);
        end
    endtask

    task automatic test_reset_mid_read;
        int seen;
        @(negedge clk);
        req_we = 1'b0; req_addr = 32'd9; vb = 1'b1;
        @(posedge clk);
        #1 vb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv_b) seen++;
        end
        checks++;
        if (seen !== 0 || ready_b !== 1'b1 || we_b !== 1'b0) begin
            fails++;
            $display("FAIL mid_read_reset: resp=%0d ready=%b we=%b required 0 1 0",
                     seen, ready_b, we_b);
        end
    endtask

`ifdef MEM_REQ_PERF_COUNT_EN
    task automatic test_perf;
        int lat;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        op_a(1'b1, 32'd10, 32'h1, lat);
        op_a(1'b1, 32'd11, 32'h2, lat);
        op_a(1'b1, 32'd12, 32'h3, lat);
        op_a(1'b0, 32'd10, 32'h0, lat);
        op_a(1'b0, 32'd11, 32'h0, lat);
        checks++;
        if (rd_a !== 32'h2) begin
            fails++;
            $display("FAIL perf_load_data: %h required 2", rd_a);
        end
        op_a(1'b0, 32'd200, 32'h0, lat);
        @(negedge clk);
        checks++;
        if (pl_a !== 16'd2) begin
            fails++;
            $display("FAIL perf_loads: %0d required 2", pl_a);
        end
        checks++;
        if (ps_a !== 16'd3) begin
            fails++;
            $display("FAIL perf_stores: %0d required 3", ps_a);
        end
        checks++;
        if (pf_a !== 16'd1) begin
            fails++;
            $display("FAIL perf_faults: %0d required 1", pf_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_store_load();
        test_range();
        test_stall();
        test_reset_mid_read();
`ifdef MEM_REQ_PERF_COUNT_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
